// File: rtl/sp_sram_ring_param_pkg.sv
// Shared types and helpers for the FIR delay-line / coefficient SRAM.
// Optional feature macro used by this slice: SP_SRAM_PARITY_EN.
package sp_sram_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } sram_state_e;

  // Legal read latencies.
  localparam int unsigned RD_LAT_ONE = 1;
  localparam int unsigned RD_LAT_TWO = 2;

  // Widest address the ring helper supports; callers zero-extend into it.
  localparam int unsigned RING_AW_MAX = 16;

  // Tap k relative to the write pointer: (ptr - 1 - k) mod depth, using one
  // conditional add of depth when the subtraction goes negative.
  function automatic logic [RING_AW_MAX-1:0] ring_addr(
    input logic [RING_AW_MAX-1:0] ptr,
    input logic [RING_AW_MAX-1:0] k,
    input logic [RING_AW_MAX:0]   depth
  );
    logic [RING_AW_MAX:0] diff;
    diff = {1'b0, ptr} - {{RING_AW_MAX{1'b0}}, 1'b1} - {1'b0, k};
    if (diff[RING_AW_MAX]) begin
      diff = diff + depth;
    end
    return diff[RING_AW_MAX-1:0];
  endfunction

endpackage

// File: rtl/sp_sram_ring_param_if.sv
// Access bus between the FIR datapath controller (master) and the SRAM (slave).
// Carries oParErr only when SP_SRAM_PARITY_EN is defined.
interface sp_sram_ring_param_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 6
);
  logic                  iCsnRam;
  logic                  iWrnRam;
  logic                  iRingMode;
  logic [ADDR_WIDTH-1:0] iAddrRam;
  logic [DATA_WIDTH-1:0] iWrDtRam;
  logic [DATA_WIDTH-1:0] oRdDtRam;
  logic                  oRdVld;
  logic                  oBusy;
  logic                  oAddrErr;
  logic [ADDR_WIDTH-1:0] oRingPtr;
`ifdef SP_SRAM_PARITY_EN
  logic                  oParErr;

  modport master (
    output iCsnRam, iWrnRam, iRingMode, iAddrRam, iWrDtRam,
    input  oRdDtRam, oRdVld, oBusy, oAddrErr, oRingPtr, oParErr
  );
  modport slave (
    input  iCsnRam, iWrnRam, iRingMode, iAddrRam, iWrDtRam,
    output oRdDtRam, oRdVld, oBusy, oAddrErr, oRingPtr, oParErr
  );
`else
  modport master (
    output iCsnRam, iWrnRam, iRingMode, iAddrRam, iWrDtRam,
    input  oRdDtRam, oRdVld, oBusy, oAddrErr, oRingPtr
  );
  modport slave (
    input  iCsnRam, iWrnRam, iRingMode, iAddrRam, iWrDtRam,
    output oRdDtRam, oRdVld, oBusy, oAddrErr, oRingPtr
  );
`endif
endinterface

// File: rtl/sp_sram_ring_param_addr_gen.sv
// Ring write pointer and effective-address / range-error generation.
module sp_sram_ring_addr_gen
  import sp_sram_pkg::*;
#(
  parameter int unsigned ADDR_DEPTH = 33,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ring_mode_i,
  input  logic                  wr_i,
  input  logic                  adv_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [ADDR_WIDTH-1:0] eff_addr_o,
  output logic                  range_err_o,
  output logic [ADDR_WIDTH-1:0] ring_ptr_o
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(ADDR_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(ADDR_DEPTH - 1);

  if (ADDR_WIDTH > RING_AW_MAX) begin : g_bad_aw
    $error("sp_sram_ring_addr_gen: ADDR_WIDTH exceeds RING_AW_MAX");
  end

  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_d;
  logic                  oor;

  assign oor = ({1'b0, addr_i} >= DEPTH_W);

  // Pointer advance with wrap after the last word.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  // Effective address: direct, ring write at the pointer, or ring tap read.
  always_comb begin
    eff_addr_o  = addr_i;
    range_err_o = oor;
    if (ring_mode_i) begin
      if (wr_i) begin
        eff_addr_o  = ptr_q;
        range_err_o = 1'b0;
      end else begin
        eff_addr_o = ADDR_WIDTH'(ring_addr(RING_AW_MAX'(ptr_q), RING_AW_MAX'(addr_i),
                                           (RING_AW_MAX+1)'(ADDR_DEPTH)));
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ring_ptr_o = ptr_q;

endmodule

// File: rtl/sp_sram_ring_param.sv
// Single-port SRAM with post-reset clear sweep, ring addressing for FIR taps,
// RD_LATENCY 1/2 read pipeline and range checking.
// Optional: SP_SRAM_PARITY_EN adds a stored even-parity bit and oParErr.
module sp_sram_ring_param
  import sp_sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_DEPTH = 33,
  parameter int unsigned ADDR_WIDTH = $clog2(ADDR_DEPTH),
  parameter int unsigned RD_LATENCY = 1
) (
  input logic                 iClk_12M,
  input logic                 iRst,
  sp_sram_ring_param_if.slave ram
);

`ifdef SP_SRAM_PARITY_EN
  localparam int unsigned WORD_W = DATA_WIDTH + 1;
`else
  localparam int unsigned WORD_W = DATA_WIDTH;
`endif
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(ADDR_DEPTH - 1);

  if (RD_LATENCY != RD_LAT_ONE && RD_LATENCY != RD_LAT_TWO) begin : g_bad_lat
    $error("sp_sram_ring_param: RD_LATENCY must be 1 or 2");
  end

  sram_state_e           state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  busy_q;
  logic [WORD_W-1:0]     mem_q [ADDR_DEPTH];

  logic                  acc, wr_acc, rd_ok, wr_ok;
  logic [ADDR_WIDTH-1:0] eff_addr, ring_ptr;
  logic                  range_err;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [WORD_W-1:0]     mem_wdata, rd_word;

  logic                  s1_vld_q, addr_err_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
`ifdef SP_SRAM_PARITY_EN
  logic                  s1_perr_q;
`endif

  assign acc    = (state_q == ST_READY) && !ram.iCsnRam && !iRst;
  assign wr_acc = acc && !ram.iWrnRam;
  assign wr_ok  = wr_acc && !range_err;
  assign rd_ok  = acc && ram.iWrnRam && !range_err;

  sp_sram_ring_addr_gen #(
    .ADDR_DEPTH (ADDR_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk_i       (iClk_12M),
    .rst_i       (iRst),
    .ring_mode_i (ram.iRingMode),
    .wr_i        (!ram.iWrnRam),
    .adv_i       (wr_acc && ram.iRingMode),
    .addr_i      (ram.iAddrRam),
    .eff_addr_o  (eff_addr),
    .range_err_o (range_err),
    .ring_ptr_o  (ring_ptr)
  );

  // Clear/ready sequencing; oBusy is registered alongside the state.
  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else if (state_q == ST_CLEAR) begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST) begin
        state_q   <= ST_READY;
        busy_q    <= 1'b0;
        clr_cnt_q <= '0;
      end
    end
  end

  // Write port mux: clear sweep has priority, otherwise an accepted write.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = eff_addr;
`ifdef SP_SRAM_PARITY_EN
    mem_wdata = {^ram.iWrDtRam, ram.iWrDtRam};
`else
    mem_wdata = ram.iWrDtRam;
`endif
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end else if (wr_ok) begin
      mem_we = 1'b1;
    end
  end

  // Storage array, deliberately without reset; the sweep initialises it.
  always_ff @(posedge iClk_12M) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_word = mem_q[eff_addr];

  // First read stage and the address-error strobe.
  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
      addr_err_q <= 1'b0;
`ifdef SP_SRAM_PARITY_EN
      s1_perr_q  <= 1'b0;
`endif
    end else begin
      s1_vld_q   <= rd_ok;
      addr_err_q <= acc && range_err;
      if (rd_ok) begin
        s1_data_q <= rd_word[DATA_WIDTH-1:0];
      end
`ifdef SP_SRAM_PARITY_EN
      s1_perr_q  <= rd_ok && (^rd_word);
`endif
    end
  end

  if (RD_LATENCY == RD_LAT_TWO) begin : g_lat2
    logic                  vld2_q;
    logic [DATA_WIDTH-1:0] data2_q;
`ifdef SP_SRAM_PARITY_EN
    logic                  perr2_q;
`endif
    // Extra output register stage; data holds when no result is moving.
    always_ff @(posedge iClk_12M) begin
      if (iRst) begin
        vld2_q  <= 1'b0;
        data2_q <= '0;
`ifdef SP_SRAM_PARITY_EN
        perr2_q <= 1'b0;
`endif
      end else begin
        vld2_q <= s1_vld_q;
        if (s1_vld_q) begin
          data2_q <= s1_data_q;
        end
`ifdef SP_SRAM_PARITY_EN
        perr2_q <= s1_perr_q;
`endif
      end
    end
    assign ram.oRdVld   = vld2_q;
    assign ram.oRdDtRam = data2_q;
`ifdef SP_SRAM_PARITY_EN
    assign ram.oParErr  = perr2_q;
`endif
  end else begin : g_lat1
    assign ram.oRdVld   = s1_vld_q;
    assign ram.oRdDtRam = s1_data_q;
`ifdef SP_SRAM_PARITY_EN
    assign ram.oParErr  = s1_perr_q;
`endif
  end

  assign ram.oBusy    = busy_q;
  assign ram.oAddrErr = addr_err_q;
  assign ram.oRingPtr = ring_ptr;

endmodule

// File: tb/tb_sp_sram_ring_param.sv
// Scoreboard bench for sp_sram_ring_param (define SP_SRAM_PARITY_EN for the
// parity test; override RD_LAT for the two-stage read build).
module tb_sp_sram_ring_param;
  parameter int unsigned RD_LAT = 1;
  localparam int unsigned DEPTH = 33;

  typedef struct {
    int unsigned due;
    logic [15:0] data;
    logic        perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #41 clk = ~clk;

  sp_sram_ring_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) bus ();

  sp_sram_ring_param #(
    .DATA_WIDTH (16),
    .ADDR_DEPTH (DEPTH),
    .RD_LATENCY (RD_LAT)
  ) dut (
    .iClk_12M (clk),
    .iRst     (rst),
    .ram      (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned edge_n = 0;
  int unsigned ready_edge = 0;
  bit          mon_en = 1'b0;
  logic [15:0] last_data = '0;
  logic [15:0] mmem [DEPTH];
  bit          mbad [DEPTH];
  int unsigned mptr = 0;
  exp_t        rd_q[$];
  int unsigned err_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // Output monitor, sampling 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    bit   exp_v, exp_e;
    edge_n++;
    #1;
    if (mon_en) begin
      exp_v = (rd_q.size() > 0) && (rd_q[0].due == edge_n);
      check_val("rd_vld", bus.oRdVld, exp_v);
      if (exp_v) begin
        e = rd_q.pop_front();
        check_val("rd_data", bus.oRdDtRam, e.data);
        last_data = e.data;
`ifdef SP_SRAM_PARITY_EN
        check_val("par_err", bus.oParErr, e.perr);
`endif
      end else begin
        check_val("rd_hold", bus.oRdDtRam, last_data);
`ifdef SP_SRAM_PARITY_EN
        check_val("par_idle", bus.oParErr, 1'b0);
`endif
      end
      exp_e = (err_q.size() > 0) && (err_q[0] == edge_n);
      check_val("addr_err", bus.oAddrErr, exp_e);
      if (exp_e) void'(err_q.pop_front());
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      bus.iCsnRam = 1'b1;
    end
  endtask

  // One access driven for the next rising edge; the model decides its effect.
  task automatic access(input logic wr, input logic ring, input int unsigned a,
                        input logic [15:0] d);
    int unsigned nxt, ea;
    logic [31:0] av;
    @(negedge clk);
    av = a;
    bus.iCsnRam   = 1'b0;
    bus.iWrnRam   = !wr;
    bus.iRingMode = ring;
    bus.iAddrRam  = av[5:0];
    bus.iWrDtRam  = d;
    nxt = edge_n + 1;
    if (nxt >= ready_edge && !rst) begin
      if (ring && wr) begin
        mmem[mptr] = d;
        mbad[mptr] = 1'b0;
        mptr = (mptr + 1) % DEPTH;
      end else if (a >= DEPTH) begin
        err_q.push_back(nxt);
      end else begin
        ea = ring ? (mptr + 2 * DEPTH - 1 - a) % DEPTH : a;
        if (wr) begin
          mmem[ea] = d;
          mbad[ea] = 1'b0;
        end else begin
          rd_q.push_back('{due: nxt + RD_LAT - 1, data: mmem[ea], perr: mbad[ea]});
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.iCsnRam = 1'b1;
    rst = 1'b1;
    rd_q.delete();
    err_q.delete();
    last_data = '0;
    mptr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mmem[i] = '0;
      mbad[i] = 1'b0;
    end
    @(negedge clk);
    check_val("rst_rdata", bus.oRdDtRam, 16'h0);
    check_val("rst_vld", bus.oRdVld, 1'b0);
    check_val("rst_err", bus.oAddrErr, 1'b0);
    check_val("rst_ptr", bus.oRingPtr, 6'd0);
    check_val("rst_busy", bus.oBusy, 1'b1);
    mon_en = 1'b1;
    rst = 1'b0;
    ready_edge = edge_n + 1 + DEPTH;
  endtask

  task automatic measure_busy();
    int unsigned n;
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      n++;
      if (!bus.oBusy || n > 200) break;
    end
    check_val("busy_len", n, DEPTH);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SP_SRAM_PARITY_EN
    logic [16:0] w;
`endif
    bus.iCsnRam = 1'b1;
    bus.iWrnRam = 1'b1;
    bus.iRingMode = 1'b0;
    bus.iAddrRam = '0;
    bus.iWrDtRam = '0;

    // 1: clear sweep length, then every word reads back zero.
    do_reset();
    measure_busy();
    for (int unsigned a = 0; a < DEPTH; a++) access(1'b0, 1'b0, a, 16'h0);
    idle(RD_LAT + 2);

    // 2: direct write then read on the following edge.
    access(1'b1, 1'b0, 5, 16'h1234);
    access(1'b0, 1'b0, 5, 16'h0);
    access(1'b1, 1'b0, 32, 16'hBEEF);
    access(1'b0, 1'b0, 32, 16'h0);
    idle(RD_LAT + 2);

    // 3: ring fill past the wrap and tap reads.
    for (int unsigned v = 1; v <= 35; v++) access(1'b1, 1'b1, 0, 16'(v));
    idle(1);
    check_val("ring_ptr", bus.oRingPtr, 6'(mptr));
    access(1'b0, 1'b1, 0, 16'h0);
    access(1'b0, 1'b1, 1, 16'h0);
    access(1'b0, 1'b1, 32, 16'h0);
    idle(RD_LAT + 2);

    // 4: out-of-range direct/ring accesses, then confirm memory unchanged.
    access(1'b0, 1'b0, 40, 16'h0);
    idle(2);
    access(1'b0, 1'b1, 33, 16'h0);
    access(1'b1, 1'b0, 33, 16'hDEAD);
    access(1'b1, 1'b0, 63, 16'hDEAD);
    idle(2);
    check_val("ptr_after_err", bus.oRingPtr, 6'(mptr));
    for (int unsigned a = 0; a < DEPTH; a++) access(1'b0, 1'b0, a, 16'h0);
    idle(RD_LAT + 2);

    // 5: accesses during the sweep, then reset at sweep cycle 10.
    do_reset();
    access(1'b1, 1'b0, 3, 16'h5555);
    access(1'b0, 1'b0, 3, 16'h0);
    access(1'b1, 1'b1, 0, 16'h7777);
    access(1'b0, 1'b0, 40, 16'h0);
    access(1'b1, 1'b0, 4, 16'hAAAA);
    idle(4);
    do_reset();
    measure_busy();
    check_val("ptr_after_clear", bus.oRingPtr, 6'd0);
    access(1'b0, 1'b0, 3, 16'h0);
    access(1'b0, 1'b0, 4, 16'h0);
    idle(RD_LAT + 2);

`ifdef SP_SRAM_PARITY_EN
    // 6: corrupt one stored bit and expect a parity strobe on its read.
    access(1'b1, 1'b0, 7, 16'h0F0F);
    access(1'b1, 1'b0, 8, 16'h1234);
    idle(1);
    @(negedge clk);
    w = dut.mem_q[7];
    w[3] = ~w[3];
    dut.mem_q[7] = w;
    mmem[7] = mmem[7] ^ 16'h0008;
    mbad[7] = 1'b1;
    access(1'b0, 1'b0, 7, 16'h0);
    access(1'b0, 1'b0, 8, 16'h0);
    idle(RD_LAT + 2);
`endif

    idle(2);
    check_val("rd_q_drained", rd_q.size(), 0);
    check_val("err_q_drained", err_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sp_sram_ring_param.md
Name: sp_sram_ring_param

Overview:
Parameterised single-port SRAM, next generation of the FIR delay-line/coefficient store.
- Adds a post-reset clear sweep (replaces the all-entry reset), a configurable read latency with a valid strobe, and out-of-range address detection.
- Adds a ring (circular delay-line) addressing mode for direct-form FIR tap storage.
- Sits between the FIR datapath controller and the MAC array.

Parameters:
DATA_WIDTH, 16, width of one stored word (signed).
ADDR_DEPTH, 33, number of words; valid addresses 0..ADDR_DEPTH-1.
ADDR_WIDTH, $clog2(ADDR_DEPTH), width of address and offset ports (6 at default).
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2; any other value is an elaboration error.

Ports:
iClk_12M  in  1  clock, rising edge; the only clock
iRst  in  1  synchronous, active-high reset
iCsnRam  in  1  chip select, active low
iWrnRam  in  1  0 = write, 1 = read
iRingMode  in  1  0 = direct addressing, 1 = ring addressing; sampled every access
iAddrRam  in  ADDR_WIDTH  direct address (mode 0) or tap offset k (mode 1)
iWrDtRam  in  DATA_WIDTH  signed write data
oRdDtRam  out  DATA_WIDTH  signed read data; holds its value between reads
oRdVld  out  1  one-cycle strobe, oRdDtRam valid
oBusy  out  1  clear sweep in progress; all accesses ignored
oAddrErr  out  1  one-cycle strobe, access had an out-of-range address/offset
oRingPtr  out  ADDR_WIDTH  current ring write pointer

Behaviour:
- Reset (iRst=1 at a clock edge):
  - oRdDtRam=0, oRdVld=0, oAddrErr=0, oRingPtr=0, oBusy=1.
  - FSM enters CLEAR with the clear counter at 0.
  - A reset asserted mid-sweep or mid-read restarts CLEAR at 0 and flushes the read pipeline.
- FSM CLEAR:
  - Writes 0 to word[cnt] each cycle; cnt increments.
  - At cnt=ADDR_DEPTH-1 the state goes to READY next cycle; oBusy drops in that same cycle.
  - Total time is ADDR_DEPTH cycles after reset deassertion.
- FSM READY:
  - Access occurs when iCsnRam=0.
  - Accesses while oBusy=1 are dropped silently (no oAddrErr, no oRdVld).
- Direct mode (iRingMode=0):
  - Effective address = iAddrRam.
  - If iAddrRam>=ADDR_DEPTH: no write, no read, oRdVld stays 0, oAddrErr pulses in the next cycle.
- Ring mode (iRingMode=1):
  - Write: stores at oRingPtr, then oRingPtr increments by 1; after ADDR_DEPTH-1 it wraps to 0. iAddrRam is ignored on writes.
  - Read of tap k = iAddrRam: address = (oRingPtr-1-k) mod ADDR_DEPTH, so k=0 is the newest sample.
  - k>=ADDR_DEPTH gives oAddrErr and no read.
  - Reads never move the pointer.
  - Direct-mode writes never move the pointer.
- Read latency:
  - A read accepted at edge N gives oRdDtRam updated and oRdVld=1 at edge N+RD_LATENCY.
  - RD_LATENCY=2 adds one output register stage.
  - Back-to-back reads give one result per cycle.
- Write latency: write data is visible to a read accepted at the next edge.
- One access per cycle (single port), so there is no simultaneous read/write case.
- Arithmetic: ring address computed in ADDR_WIDTH+1 bits, with one conditional add of ADDR_DEPTH when the result is negative. No modulo divider.

Optional Feature:
SP_SRAM_PARITY_EN
- Defined:
  - Each word stores one extra even-parity bit, computed on write and written as 0 during CLEAR.
  - On read, parity is checked; a mismatch gives output oParErr (1 bit, reset 0) pulsing in the same cycle as oRdVld.
  - Read data is still returned.
- Undefined: no parity storage, no oParErr port.

Decomposition:
- Package sp_sram_pkg:
  - FSM state enum (ST_CLEAR, ST_READY).
  - RD_LATENCY legal-value constants.
  - Function ring_addr(ptr, k, depth).
- One sub-module, sp_sram_ring_addr_gen:
  - Owns oRingPtr, pointer wrap, and tap-offset address computation.
  - Outputs effective address plus range-error flag.

Test Plan:
1. Reset then idle with defaults → oBusy=1 for exactly 33 cycles after iRst falls; direct reads of addresses 0..32 → all return 0 with oRdVld one cycle after each request.
2. Direct write 0x1234 to address 5, read address 5 next cycle → oRdDtRam=0x1234 with oRdVld at +1 cycle (RD_LATENCY=1) and +2 cycles (RD_LATENCY=2 build).
3. Ring-mode writes of values 1..35 (35 writes, depth 33) → oRingPtr=2; tap reads k=0,1,32 → 35, 34, 3.
4. Direct read of address 40, and ring read with k=33 → oAddrErr pulse each time, no oRdVld, oRdDtRam unchanged; a write to address 33 → memory unchanged.
5. Accesses during CLEAR, plus iRst asserted at sweep cycle 10 → writes dropped, oBusy restarts a full 33-cycle sweep, no strobes.
6. With SP_SRAM_PARITY_EN defined, force-flip one stored bit via the bench, then read → oParErr=1 together with oRdVld; unmodified words give oParErr=0.
